// File: rtl/marquee_step_gen_pkg.sv
// Shared types and constants for the marquee position stepper.
// pos_step() is the single place that defines the wrap arithmetic.
package marquee_step_gen_pkg;

  localparam int POS_W = 3;
  localparam int NPOS  = 6;

  typedef enum logic {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic logic [POS_W-1:0] pos_step(
    input logic [POS_W-1:0] pos,
    input logic             dir,
    input logic [POS_W-1:0] last
  );
    logic [POS_W-1:0] nxt;
    if (dir) begin
      nxt = (pos == {POS_W{1'b0}}) ? last : pos - POS_W'(1);
    end else begin
      nxt = (pos == last) ? {POS_W{1'b0}} : pos + POS_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/marquee_step_gen_if.sv
// Control/status bundle between the board I/O and the position stepper.
interface marquee_step_gen_if;
  import marquee_step_gen_pkg::*;

  logic             KEY_RUN;
  logic             KEY_STEP;
  logic             DIR;
  logic [1:0]       SPEED;
  logic [POS_W-1:0] POS;
  logic             RUNNING;
  logic             TICK;

  modport master (
    output KEY_RUN, KEY_STEP, DIR, SPEED,
    input  POS, RUNNING, TICK
  );

  modport slave (
    input  KEY_RUN, KEY_STEP, DIR, SPEED,
    output POS, RUNNING, TICK
  );

endinterface

// File: rtl/marquee_step_gen_key_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter, and a
// one-cycle press pulse on each accepted released->pressed transition.
module key_debounce
  import marquee_step_gen_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic CLOCK_50,
  input  logic RESET,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_settled;

  // The counter only runs while the input disagrees with the accepted level,
  // so any bounce back to the old level restarts the qualification window.
  assign w_settled = (r_sync2 != r_stable) && (r_cnt == CNT_LAST);

  // Synchroniser, stability counter and press pulse register.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= {CNT_W{1'b0}};
      r_press  <= 1'b0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_press <= w_settled && !r_sync2;
      if (r_sync2 == r_stable) begin
        r_cnt <= {CNT_W{1'b0}};
      end else if (w_settled) begin
        r_stable <= r_sync2;
        r_cnt    <= {CNT_W{1'b0}};
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/marquee_step_gen.sv
// Timed/button-driven scroller producing the display position select.
// Holds the run/pause FSM, the speed-dependent prescaler and the POS wrap.
module marquee_step_gen
  import marquee_step_gen_pkg::*;
#(
  parameter int BASE_DIV   = 12_500_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int NPOS       = marquee_step_gen_pkg::NPOS
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  marquee_step_gen_if.slave  bus
);

  localparam int PRE_W = $clog2(BASE_DIV * 8);
  localparam logic [PRE_W-1:0] LAST_S0  = PRE_W'(BASE_DIV * 8 - 1);
  localparam logic [PRE_W-1:0] LAST_S1  = PRE_W'(BASE_DIV * 4 - 1);
  localparam logic [PRE_W-1:0] LAST_S2  = PRE_W'(BASE_DIV * 2 - 1);
  localparam logic [PRE_W-1:0] LAST_S3  = PRE_W'(BASE_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NPOS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PRE_W-1:0] r_pre;
  logic [PRE_W-1:0] w_pre_nxt;
  logic [PRE_W-1:0] w_last;
  logic [POS_W-1:0] r_pos;
  logic             r_tick;
  logic             r_running;
  logic             w_step;
  logic             w_run_evt;
  logic             w_step_evt;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .key_n    (bus.KEY_RUN),
    .press    (w_run_evt)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .CLOCK_50 (CLOCK_50),
    .RESET    (RESET),
    .key_n    (bus.KEY_STEP),
    .press    (w_step_evt)
  );

  // Terminal prescaler count for the current speed; not latched, so a
  // speed change takes effect on the very next comparison.
  always_comb begin
    w_last = LAST_S3;
    case (bus.SPEED)
      2'd0:    w_last = LAST_S0;
      2'd1:    w_last = LAST_S1;
      2'd2:    w_last = LAST_S2;
      2'd3:    w_last = LAST_S3;
      default: w_last = LAST_S3;
    endcase
  end

  // Next-state logic; a run toggle always takes priority over any step.
  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_step      = 1'b0;
    case (r_state)
      ST_PAUSE: begin
        w_pre_nxt = {PRE_W{1'b0}};
        if (w_run_evt) begin
          w_state_nxt = ST_RUN;
        end else if (w_step_evt) begin
          w_step = 1'b1;
        end else begin
          w_step = 1'b0;
        end
      end
      ST_RUN: begin
        if (w_run_evt) begin
          w_state_nxt = ST_PAUSE;
          w_pre_nxt   = {PRE_W{1'b0}};
        end else if (r_pre >= w_last) begin
          // '>=' catches a count already past a freshly shortened period
          w_pre_nxt = {PRE_W{1'b0}};
          w_step    = 1'b1;
        end else begin
          w_pre_nxt = r_pre + PRE_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_PAUSE;
        w_pre_nxt   = {PRE_W{1'b0}};
      end
    endcase
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_state   <= ST_PAUSE;
      r_pre     <= {PRE_W{1'b0}};
      r_pos     <= {POS_W{1'b0}};
      r_tick    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre     <= w_pre_nxt;
      r_tick    <= w_step;
      r_running <= (w_state_nxt == ST_RUN);
      if (w_step) begin
        r_pos <= pos_step(r_pos, bus.DIR, POS_LAST);
      end else begin
        r_pos <= r_pos;
      end
    end
  end

  assign bus.POS     = r_pos;
  assign bus.TICK    = r_tick;
  assign bus.RUNNING = r_running;

endmodule

// File: tb/tb_marquee_step_gen.sv
// Bench for marquee_step_gen: directed vector table, a hand-built corner
// sequence, and random stimulus checked every cycle against a window model.
module tb_marquee_step_gen;
  import marquee_step_gen_pkg::*;

  localparam int TB_NPOS = 6;
  localparam int TB_BASE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  marquee_step_gen_if bus_if ();

  marquee_step_gen #(
    .BASE_DIV   (TB_BASE),
    .DEB_CYCLES (3),
    .NPOS       (TB_NPOS)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus_if)
  );

  // Reference model: a key is accepted once three consecutive synchronised
  // samples disagree with the accepted level; steps are timed as elapsed
  // cycles against the period 4 << (3-SPEED); POS moves modulo NPOS.
  int q_run[$];
  int q_step[$];
  int m_lvl_run, m_lvl_step, m_evt_run, m_evt_step;
  int m_running, m_elapsed, m_pos, m_tick;

  task automatic model_reset();
    q_run      = {1, 1, 1, 1};
    q_step     = {1, 1, 1, 1};
    m_lvl_run  = 1;
    m_lvl_step = 1;
    m_evt_run  = 0;
    m_evt_step = 0;
    m_running  = 0;
    m_elapsed  = 0;
    m_pos      = 0;
    m_tick     = 0;
  endtask

  task automatic model_edge(input logic kr, input logic ks, input logic d, input logic [1:0] sp);
    int run_evt, step_evt, new_run, new_step, period, do_step;
    run_evt  = m_evt_run;
    step_evt = m_evt_step;
    q_run.push_back(int'(kr));
    q_step.push_back(int'(ks));
    if (q_run.size() > 5) void'(q_run.pop_front());
    if (q_step.size() > 5) void'(q_step.pop_front());
    new_run  = 0;
    new_step = 0;
    if (q_run[0] != m_lvl_run && q_run[1] != m_lvl_run && q_run[2] != m_lvl_run) begin
      new_run   = (q_run[0] == 0) ? 1 : 0;
      m_lvl_run = q_run[0];
    end
    if (q_step[0] != m_lvl_step && q_step[1] != m_lvl_step && q_step[2] != m_lvl_step) begin
      new_step   = (q_step[0] == 0) ? 1 : 0;
      m_lvl_step = q_step[0];
    end
    m_evt_run  = new_run;
    m_evt_step = new_step;
    period  = TB_BASE << (3 - int'(sp));
    do_step = 0;
    if (run_evt != 0) begin
      m_running = 1 - m_running;
      m_elapsed = 0;
    end else if (m_running == 0) begin
      do_step = step_evt;
    end else if (m_elapsed + 1 >= period) begin
      m_elapsed = 0;
      do_step   = 1;
    end else begin
      m_elapsed = m_elapsed + 1;
    end
    m_tick = do_step;
    if (do_step != 0) m_pos = d ? (m_pos + TB_NPOS - 1) % TB_NPOS : (m_pos + 1) % TB_NPOS;
  endtask

  task automatic check_model();
    n_checks++;
    if (bus_if.POS !== 3'(m_pos) || bus_if.RUNNING !== 1'(m_running) || bus_if.TICK !== 1'(m_tick)) begin
      n_errors++;
      $display("FAIL model t=%0t pos=%0d exp %0d running=%0d exp %0d tick=%0d exp %0d",
               $time, bus_if.POS, m_pos, bus_if.RUNNING, m_running, bus_if.TICK, m_tick);
    end
  endtask

  task automatic check_const(input string name, input logic [2:0] pos, input logic run, input logic tick);
    n_checks++;
    if (bus_if.POS !== pos || bus_if.RUNNING !== run || bus_if.TICK !== tick) begin
      n_errors++;
      $display("FAIL %s pos=%0d exp %0d running=%0d exp %0d tick=%0d exp %0d",
               name, bus_if.POS, pos, bus_if.RUNNING, run, bus_if.TICK, tick);
    end
  endtask

  task automatic cycle(input logic r, input logic kr, input logic ks, input logic d, input logic [1:0] sp);
    @(negedge clk);
    rst             = r;
    bus_if.KEY_RUN  = kr;
    bus_if.KEY_STEP = ks;
    bus_if.DIR      = d;
    bus_if.SPEED    = sp;
    @(posedge clk);
    if (r) model_reset();
    else   model_edge(kr, ks, d, sp);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       rst;
    logic       krun;
    logic       kstep;
    logic       dir;
    logic [1:0] spd;
    int         ncyc;
    logic [2:0] pos;
    logic       run;
    logic       tick;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic r, input logic kr, input logic ks, input logic d, input logic [1:0] sp,
                         input int n, input logic [2:0] p, input logic ru, input logic t);
    vec_t v;
    v.rst = r; v.krun = kr; v.kstep = ks; v.dir = d; v.spd = sp;
    v.ncyc = n; v.pos = p; v.run = ru; v.tick = t;
    tbl.push_back(v);
  endtask

  initial begin
    logic kr_lvl, ks_lvl, d_r, r_r;
    logic [1:0] sp_r;
    int kr_left, ks_left;
    bus_if.KEY_RUN  = 1'b1;
    bus_if.KEY_STEP = 1'b1;
    bus_if.DIR      = 1'b0;
    bus_if.SPEED    = 2'd3;
    model_reset();

    //       rst   krun  kstep dir   spd  n    pos  run   tick
    add_vec(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 2,   3'd0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 100, 3'd0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 5,   3'd0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1,   3'd0, 1'b1, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 4,   3'd1, 1'b1, 1'b1);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 20,  3'd0, 1'b1, 1'b1);
    add_vec(1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 4,   3'd5, 1'b1, 1'b1);
    add_vec(1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 4,   3'd4, 1'b1, 1'b1);
    add_vec(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 5,   3'd3, 1'b1, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 1,   3'd3, 1'b0, 1'b0);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1,   3'd0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 5,   3'd0, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1,   3'd1, 1'b0, 1'b1);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 6,   3'd1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 5,   3'd1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1,   3'd2, 1'b0, 1'b1);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 6,   3'd2, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 5,   3'd2, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1,   3'd3, 1'b0, 1'b1);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 6,   3'd3, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 50,  3'd4, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 8,   3'd4, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 1,   3'd4, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 3,   3'd4, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2,   3'd4, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 4,   3'd4, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5,   3'd4, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1,   3'd4, 1'b1, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32,  3'd5, 1'b1, 1'b1);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 20,  3'd5, 1'b1, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1,   3'd0, 1'b1, 1'b1);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5,   3'd1, 1'b1, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1,   3'd1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 6,   3'd1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 5,   3'd1, 1'b0, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 1,   3'd1, 1'b1, 1'b0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 12,  3'd4, 1'b1, 1'b1);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0, 2'd3, 1,   3'd0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].ncyc; c++) begin
        cycle(tbl[i].rst, tbl[i].krun, tbl[i].kstep, tbl[i].dir, tbl[i].spd);
      end
      check_const($sformatf("vec%0d", i), tbl[i].pos, tbl[i].run, tbl[i].tick);
    end

    // Run toggle arriving exactly at the prescaler terminal count: no step.
    for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
    check_const("run_enter", 3'd0, 1'b1, 1'b0);
    for (int c = 0; c < 2; c++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
    for (int c = 0; c < 5; c++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 2'd3);
    check_const("pre_terminal", 3'd1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 2'd3);
    check_const("run_evt_at_terminal", 3'd1, 1'b0, 1'b0);

    kr_lvl = 1'b1; ks_lvl = 1'b1; kr_left = 0; ks_left = 0;
    d_r = 1'b0; sp_r = 2'd3;
    for (int c = 0; c < 3000; c++) begin
      if (kr_left == 0) begin
        kr_lvl  = 1'($urandom_range(0, 1));
        kr_left = int'($urandom_range(1, 12));
      end
      if (ks_left == 0) begin
        ks_lvl  = 1'($urandom_range(0, 1));
        ks_left = int'($urandom_range(1, 10));
      end
      kr_left--;
      ks_left--;
      if ($urandom_range(0, 39) == 0) d_r = ~d_r;
      if ($urandom_range(0, 59) == 0) sp_r = 2'($urandom_range(0, 3));
      r_r = ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0;
      cycle(r_r, kr_lvl, ks_lvl, d_r, sp_r);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
